// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with done handshake, auto-reload and sticky overrun
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             abort,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nx;
  logic             ar_reg;
  logic             ar_nx;
  logic             done_nx;
  logic             overrun_nx;
  logic             accept;

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = done_valid & done_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      ar_reg     <= 1'b0;
      done_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      reload_reg <= reload_nx;
      ar_reg     <= ar_nx;
      done_valid <= done_nx;
      overrun    <= overrun_nx;
    end
  end

  // Accept clears done_valid by default; a terminal edge below re-asserts it.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    reload_nx  = reload_reg;
    ar_nx      = ar_reg;
    done_nx    = done_valid & ~accept;
    overrun_nx = overrun;
    if (abort) begin
      state_nx = IDLE;
      count_nx = '0;
      done_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            count_nx   = load_value;
            reload_nx  = load_value;
            overrun_nx = 1'b0;
            ar_nx      = auto_reload & (load_value != '0);
            if (load_value != '0) begin
              state_nx = RUN;
            end else begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (count > WIDTH'(1)) begin
              count_nx = count - WIDTH'(1);
            end else if (ar_reg) begin
              count_nx = reload_reg;
              done_nx  = 1'b1;
              if (done_valid && !done_ready) overrun_nx = 1'b1;
            end else begin
              count_nx = '0;
              done_nx  = 1'b1;
              state_nx = DONE;
            end
          end
        end
        DONE: begin
          if (accept) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
module tb_countdown_timer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid = 1'b0;
  logic             auto_reload = 1'b0;
  logic             enable = 1'b0;
  logic             abort = 1'b0;
  logic             done_ready = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             load_ready;
  logic             done_valid;
  logic             busy;
  logic             overrun;
  logic [WIDTH-1:0] count;

  int checks = 0;
  int errors = 0;
  int lat_q[$];
  logic [WIDTH-1:0] cnt_q[$];

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .auto_reload(auto_reload), .enable(enable), .abort(abort),
    .done_valid(done_valid), .done_ready(done_ready), .count(count), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v, input logic a);
    load_valid  = 1'b1;
    load_value  = v;
    auto_reload = a;
    step();
    load_valid  = 1'b0;
    auto_reload = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] exp_c;
    int exp_l;
    bit seen;
    seen = 1'b0;
    enable = 1'b1;
    done_ready = 1'b1;
    for (int i = 0; i <= 5; i++) cnt_q.push_back(WIDTH'(5 - i));
    lat_q.push_back(5);
    do_load(8'd5, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      exp_c = cnt_q.pop_front();
      checks++; if (count !== exp_c) begin errors++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, count, exp_c); end
      if (done_valid && !seen) begin
        seen = 1'b1;
        exp_l = lat_q.pop_front();
        checks++; if (i != exp_l) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", i, exp_l); end
      end
      if (i < 5) step();
    end
    if (!seen) begin checks++; errors++; $display("FAIL basic_done: got none expected done after 5 edges"); lat_q.delete(); end
    step();
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done_valid); end
    checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got ready=%b busy=%b expected 1 0", load_ready, busy); end
  endtask

  task automatic test_pause();
    int exp_l;
    bit seen;
    seen = 1'b0;
    enable = 1'b1;
    done_ready = 1'b1;
    lat_q.push_back(7);
    do_load(8'd4, 1'b0);
    for (int e = 1; e <= 20 && !seen; e++) begin
      enable = !(e >= 3 && e <= 5);
      step();
      if (e == 5) begin
        checks++; if (count !== 8'd2) begin errors++; $display("FAIL pause_freeze: got %0d expected 2", count); end
      end
      if (done_valid) begin
        seen = 1'b1;
        exp_l = lat_q.pop_front();
        checks++; if (e != exp_l) begin errors++; $display("FAIL pause_latency: got %0d expected %0d", e, exp_l); end
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL pause_final_count: got %0d expected 0", count); end
      end
    end
    enable = 1'b1;
    if (!seen) begin checks++; errors++; $display("FAIL pause_timeout: got no done expected done at 7"); lat_q.delete(); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pause_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_autoreload();
    logic [WIDTH-1:0] exp_c;
    int exp_l;
    enable = 1'b1;
    done_ready = 1'b1;
    for (int i = 0; i <= 9; i++) cnt_q.push_back(WIDTH'(3 - (i % 3)));
    lat_q.push_back(3); lat_q.push_back(6); lat_q.push_back(9);
    do_load(8'd3, 1'b1);
    for (int i = 0; i <= 9; i++) begin
      exp_c = cnt_q.pop_front();
      checks++; if (count !== exp_c) begin errors++; $display("FAIL ar_count[%0d]: got %0d expected %0d", i, count, exp_c); end
      if (done_valid) begin
        exp_l = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        checks++; if (i != exp_l) begin errors++; $display("FAIL ar_tick: got edge %0d expected %0d", i, exp_l); end
      end
      if (i < 9) step();
    end
    checks++; if (lat_q.size() != 0) begin errors++; $display("FAIL ar_missing_ticks: got %0d pending expected 0", lat_q.size()); end
    lat_q.delete();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ar_overrun: got %b expected 0", overrun); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("FAIL ar_abort: got count=%0d busy=%b done=%b expected 0 0 0", count, busy, done_valid); end
  endtask

  task automatic test_overrun();
    enable = 1'b1;
    done_ready = 1'b0;
    do_load(8'd2, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 2) begin
        checks++; if (done_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_tick: got done=%b ovr=%b expected 1 0", done_valid, overrun); end
      end
      if (i == 4) begin
        checks++; if (done_valid !== 1'b1 || overrun !== 1'b1 || count !== 8'd2) begin errors++; $display("FAIL ovr_second_tick: got done=%b ovr=%b count=%0d expected 1 1 2", done_valid, overrun, count); end
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ovr_after_abort: got ovr=%b busy=%b expected 1 0", overrun, busy); end
    do_load(8'd1, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear_on_load: got %b expected 0", overrun); end
    step();
    done_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_zero();
    int exp_l;
    done_ready = 1'b0;
    lat_q.push_back(0);
    do_load(8'd0, 1'b1);
    exp_l = lat_q.pop_front();
    checks++; if (!(done_valid === 1'b1 && exp_l == 0)) begin errors++; $display("FAIL zero_done: got %b expected 1 at latency %0d", done_valid, exp_l); end
    checks++; if (count !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL zero_state: got count=%0d busy=%b expected 0 1", count, busy); end
    done_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || load_ready !== 1'b1 || done_valid !== 1'b0) begin errors++; $display("FAIL zero_accept: got busy=%b ready=%b done=%b expected 0 1 0", busy, load_ready, done_valid); end
  endtask

  task automatic test_all_ones();
    enable = 1'b1;
    do_load(8'hff, 1'b0);
    checks++; if (count !== 8'hff) begin errors++; $display("FAIL ones_load: got %0d expected 255", count); end
    step();
    checks++; if (count !== 8'hfe) begin errors++; $display("FAIL ones_dec: got %0d expected 254", count); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    do_load(8'd200, 1'b0);
    repeat (100) step();
    checks++; if (count !== 8'd100) begin errors++; $display("FAIL mid_count: got %0d expected 100", count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || load_ready !== 1'b1 || done_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL mid_async_reset: got count=%0d busy=%b ready=%b done=%b ovr=%b expected 0 0 1 0 0", count, busy, load_ready, done_valid, overrun);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_busy_load();
    enable = 1'b1;
    done_ready = 1'b0;
    do_load(8'd3, 1'b0);
    load_valid = 1'b1;
    load_value = 8'd9;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", load_ready); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (count !== WIDTH'(3 - i)) begin errors++; $display("FAIL busy_count[%0d]: got %0d expected %0d", i, count, 3 - i); end
    end
    checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL busy_done: got %b expected 1", done_valid); end
    load_valid = 1'b0;
    done_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL busy_idle: got busy=%b count=%0d expected 0 0", busy, count); end
  endtask

  task automatic test_abort_load();
    load_valid = 1'b1;
    load_value = 8'd7;
    abort = 1'b1;
    step();
    load_valid = 1'b0;
    abort = 1'b0;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL abort_wins: got count=%0d busy=%b ready=%b expected 0 0 1", count, busy, load_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_autoreload();
    test_overrun();
    test_zero();
    test_all_ones();
    test_reset_mid();
    test_busy_load();
    test_abort_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
